// File: rtl/key_autorepeat_if.sv
// Key/pulse bundle for key_autorepeat: raw active-low keys in, per-channel pulse/held levels
// and the global repeating flag out.
interface key_autorepeat_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] iKeys;
   logic [CHANNELS-1:0] oPulse;
   logic [CHANNELS-1:0] oHeld;
   logic                oRepeating;

   modport master (output iKeys, input oPulse, input oHeld, input oRepeating);
   modport slave  (input iKeys, output oPulse, output oHeld, output oRepeating);
endinterface

// File: rtl/key_autorepeat.sv
// Per-channel key press / auto-repeat pulse generator with slow and fast repeat phases.
// Define KEY_AUTOREPEAT_DEBOUNCE_EN to insert a stable-time debounce filter after the synchroniser.
module key_autorepeat #(
   parameter int                  CHANNELS        = 4,
   parameter int                  CLOCK_PERIOD_NS = 20,
   parameter int                  PAUSE_NS        = 250_000_000,
   parameter int                  REPEAT_NS       = 150_000_000,
   parameter int                  FAST_NS         = 50_000_000,
   parameter int                  FAST_AFTER      = 8,
   parameter logic [CHANNELS-1:0] NO_REPEAT_MASK  = '0,
   parameter int                  DEBOUNCE_NS     = 5_000_000
) (
   input logic             Clock,
   input logic             Reset,
   key_autorepeat_if.slave bus
);
   localparam int MaxPause  = PAUSE_NS / CLOCK_PERIOD_NS;
   localparam int MaxRepeat = REPEAT_NS / CLOCK_PERIOD_NS;
   localparam int MaxFast   = FAST_NS / CLOCK_PERIOD_NS;
   localparam int MaxPR     = (MaxPause > MaxRepeat) ? MaxPause : MaxRepeat;
   localparam int MaxCount  = (MaxPR > MaxFast) ? MaxPR : MaxFast;
   localparam int CW        = $clog2(MaxCount) + 1;
   localparam int RW        = $clog2(FAST_AFTER + 1);

   if (MaxPause < 2 || MaxRepeat < 2 || MaxFast < 2) begin : g_bad_count
      $error("key_autorepeat: derived pause/repeat/fast cycle counts must all be at least 2");
   end
   if (FAST_AFTER < 1) begin : g_bad_fast_after
      $error("key_autorepeat: FAST_AFTER must be at least 1");
   end

   typedef enum logic [2:0] {IDLE, PAUSE, HOLD, REPEAT, FAST} state_t;

   logic [CHANNELS-1:0] sync1_reg;
   logic [CHANNELS-1:0] sync2_reg;
   logic [CHANNELS-1:0] key_n;       // conditioned key, still active-low
   logic [CHANNELS-1:0] pulse_vec;
   logic [CHANNELS-1:0] held_vec;
   logic [CHANNELS-1:0] rep_vec;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync1_reg <= '1;
         sync2_reg <= '1;
      end else begin
         sync1_reg <= bus.iKeys;
         sync2_reg <= sync1_reg;
      end
   end

`ifdef KEY_AUTOREPEAT_DEBOUNCE_EN
   localparam int MaxDebounce = DEBOUNCE_NS / CLOCK_PERIOD_NS;
   localparam int DW          = $clog2(MaxDebounce + 1) + 1;

   if (MaxDebounce < 1) begin : g_bad_debounce
      $error("key_autorepeat: DEBOUNCE_NS must cover at least one clock period");
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_debounce
      logic [DW-1:0] db_cnt_reg;
      logic          db_reg;

      // Counts consecutive cycles where the input disagrees with the output; any agreement restarts it.
      always_ff @(posedge Clock) begin
         if (Reset) begin
            db_reg     <= 1'b1;
            db_cnt_reg <= '0;
         end else if (sync2_reg[gi] == db_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == DW'(MaxDebounce - 1)) begin
            db_reg     <= sync2_reg[gi];
            db_cnt_reg <= '0;
         end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
         end
      end

      assign key_n[gi] = db_reg;
   end
`else
   if (DEBOUNCE_NS < 0) begin : g_bad_debounce
      $error("key_autorepeat: DEBOUNCE_NS must not be negative");
   end

   assign key_n = sync2_reg;
`endif

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      state_t        state_reg, state_next;
      logic [CW-1:0] cnt_reg, cnt_next;
      logic [RW-1:0] rpt_reg, rpt_next;
      logic          pulse_reg, pulse_next;
      logic          pressed;

      assign pressed = ~key_n[gi];

      always_ff @(posedge Clock) begin
         if (Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rpt_reg   <= '0;
            pulse_reg <= 1'b0;
         end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rpt_reg   <= rpt_next;
            pulse_reg <= pulse_next;
         end
      end

      always_comb begin
         state_next = state_reg;
         cnt_next   = cnt_reg;
         rpt_next   = rpt_reg;
         pulse_next = 1'b0;
         if (!pressed) begin
            state_next = IDLE;
            cnt_next   = '0;
            rpt_next   = '0;
         end else begin
            unique case (state_reg)
               IDLE: begin
                  pulse_next = 1'b1;
                  cnt_next   = '0;
                  state_next = PAUSE;
               end
               PAUSE: begin
                  if (cnt_reg == CW'(MaxPause - 1)) begin
                     cnt_next = '0;
                     if (NO_REPEAT_MASK[gi]) begin
                        state_next = HOLD;
                     end else begin
                        pulse_next = 1'b1;
                        state_next = REPEAT;
                     end
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
               HOLD: begin
                  cnt_next = '0;
               end
               REPEAT: begin
                  if (cnt_reg == CW'(MaxRepeat - 1)) begin
                     cnt_next   = '0;
                     pulse_next = 1'b1;
                     // The repeat counter parks at FAST_AFTER once the fast phase starts.
                     if (rpt_reg == RW'(FAST_AFTER - 1)) begin
                        rpt_next   = RW'(FAST_AFTER);
                        state_next = FAST;
                     end else begin
                        rpt_next = rpt_reg + 1'b1;
                     end
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
               FAST: begin
                  if (cnt_reg == CW'(MaxFast - 1)) begin
                     cnt_next   = '0;
                     pulse_next = 1'b1;
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
               default: begin
                  state_next = IDLE;
                  cnt_next   = '0;
                  rpt_next   = '0;
               end
            endcase
         end
      end

      assign pulse_vec[gi] = pulse_reg;
      assign held_vec[gi]  = (state_reg != IDLE);
      assign rep_vec[gi]   = (state_reg == REPEAT) || (state_reg == FAST);
   end

   assign bus.oPulse     = pulse_vec;
   assign bus.oHeld      = held_vec;
   assign bus.oRepeating = |rep_vec;
endmodule
